// File: rtl/sd_otf_converter_if.sv
// sd_otf_converter_if
//   Bundles the control, digit and result signals of the on-the-fly converter.
//   master : the producer side (digit-vector store / sequencer) driving digits and control.
//   slave  : the converter side, consuming digits and presenting the result.
//   Ports carried:
//     write_enable, error_flag, start, digit_valid, digit_in[1:0]  (master -> slave)
//     busy, result[NUM_DIGITS:0], result_valid, aborted, digit_cnt  (slave -> master)
interface sd_otf_converter_if #(
  parameter int NUM_DIGITS = 32,
  parameter int CNT_W      = 7
);
  logic                  write_enable;
  logic                  error_flag;
  logic                  start;
  logic                  digit_valid;
  logic [1:0]            digit_in;
  logic                  busy;
  logic [NUM_DIGITS:0]   result;
  logic                  result_valid;
  logic                  aborted;
  logic [CNT_W-1:0]      digit_cnt;

  modport master (
    output write_enable, error_flag, start, digit_valid, digit_in,
    input  busy, result, result_valid, aborted, digit_cnt
  );

  modport slave (
    input  write_enable, error_flag, start, digit_valid, digit_in,
    output busy, result, result_valid, aborted, digit_cnt
  );
endinterface

// File: rtl/sd_otf_converter.sv
// sd_otf_converter
//   Digit-serial on-the-fly converter. Accepts one radix-2 signed digit per cycle, MSD first,
//   in {plus,minus} encoding (10=+1, 01=-1, 00/11=0) and builds the two's-complement value
//   with the Q/QM register pair, so no carry-propagate add is needed at the end.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : sd_otf_converter_if slave modport
//              inputs  write_enable (global stall), error_flag (abort), start, digit_valid, digit_in
//              outputs busy, result (value*2^NUM_DIGITS), result_valid / aborted (1-cycle pulses),
//                      digit_cnt (digits accepted in the current conversion)
module sd_otf_converter #(
  parameter int NUM_DIGITS = 32,
  parameter int CNT_W      = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_otf_converter_if.slave    bus
);

  localparam int W = NUM_DIGITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     q;
  logic [W-1:0]     qm;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic [W-1:0]     result_r;
  logic             result_valid_r;
  logic             aborted_r;

  // Digit decode: 11 is a redundant zero, so plus/minus are only honoured when exclusive.
  logic dig_plus;
  logic dig_minus;
  assign dig_plus  = bus.digit_in[1] & ~bus.digit_in[0];
  assign dig_minus = bus.digit_in[0] & ~bus.digit_in[1];

  // Q holds the converted prefix, QM holds that prefix minus one ulp. Appending a digit only
  // ever selects one of the two and concatenates a constant bit, which is why no adder exists.
  // The bit shifted out of the top is dropped: the final value always fits in W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      q              <= '0;
      qm             <= '1;
      cnt            <= '0;
      busy_r         <= 1'b0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      aborted_r      <= 1'b0;
    end else if (bus.write_enable) begin
      // Pulses are cleared on every enabled cycle and only re-set by the state that owns them.
      result_valid_r <= 1'b0;
      aborted_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            q      <= '0;
            qm     <= '1;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          if (bus.error_flag) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
          end else if (bus.digit_valid) begin
            if (dig_plus) begin
              q  <= {q[W-2:0], 1'b1};
              qm <= {q[W-2:0], 1'b0};
            end else if (dig_minus) begin
              q  <= {qm[W-2:0], 1'b1};
              qm <= {qm[W-2:0], 1'b0};
            end else begin
              q  <= {q[W-2:0], 1'b0};
              qm <= {qm[W-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
              state  <= DONE;
              busy_r <= 1'b0;
            end
          end
        end
        DONE: begin
          result_r       <= q;
          result_valid_r <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.aborted      = aborted_r;
  assign bus.digit_cnt    = cnt;

  // QM must track Q-1 throughout a conversion; any divergence means a corrupted select path.
  qm_tracks_q: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (qm == W'(q - 1'b1)));

endmodule

// File: tb/tb_sd_otf_converter.sv
module tb_sd_otf_converter;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  sd_otf_converter_if #(.NUM_DIGITS(4),  .CNT_W(3)) b4 ();
  sd_otf_converter_if #(.NUM_DIGITS(32), .CNT_W(7)) b32 ();

  sd_otf_converter #(.NUM_DIGITS(4), .CNT_W(3)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  sd_otf_converter #(.NUM_DIGITS(32), .CNT_W(7)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] digits;
    logic [4:0] expected;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Starts a 4-digit conversion and feeds the digits MSD first on consecutive cycles.
  task automatic applyStimulus(input logic [7:0] digits);
    logic [7:0] d;
    d = digits;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b4.digit_valid = 1'b1;
      b4.digit_in    = d[7:6];
      d              = d << 2;
      tick();
    end
    b4.digit_valid = 1'b0;
    b4.digit_in    = 2'b00;
  endtask

  task automatic feedDigit(input logic [1:0] dig);
    b4.digit_valid = 1'b1;
    b4.digit_in    = dig;
    tick();
    b4.digit_valid = 1'b0;
    b4.digit_in    = 2'b00;
  endtask

  initial begin
    logic [32:0] exp32;
    longint      acc;
    logic [1:0]  rd;
    bit          seen;

    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{"case1_pos",      8'b10_00_01_10, 5'b00111};
    vecs[1] = '{"case2_all_neg",  8'b01_01_01_01, 5'b10001};
    vecs[2] = '{"case2_all_pos",  8'b10_10_10_10, 5'b01111};
    vecs[3] = '{"case3_redund",   8'b11_10_11_01, 5'b00011};
    vecs[4] = '{"all_zero",       8'b00_00_00_00, 5'b00000};
    vecs[5] = '{"neg_sixteenth",  8'b01_10_10_10, 5'b11111};

    {b4.write_enable, b4.error_flag, b4.start, b4.digit_valid} = 4'b1000;
    b4.digit_in = 2'b00;
    {b32.write_enable, b32.error_flag, b32.start, b32.digit_valid} = 4'b1000;
    b32.digit_in = 2'b00;

    rst_n = 1'b0;
    #12;
    checkOutput("reset_busy",    64'(b4.busy),         64'd0);
    checkOutput("reset_result",  64'(b4.result),       64'd0);
    checkOutput("reset_valid",   64'(b4.result_valid), 64'd0);
    checkOutput("reset_aborted", 64'(b4.aborted),      64'd0);
    checkOutput("reset_cnt",     64'(b4.digit_cnt),    64'd0);
    rst_n = 1'b1;
    tick();

    // Table of complete 4-digit conversions.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].digits);
      checkOutput({vecs[v].name, "_busy_after_last"}, 64'(b4.busy),         64'd0);
      checkOutput({vecs[v].name, "_valid_early"},     64'(b4.result_valid), 64'd0);
      tick();
      checkOutput({vecs[v].name, "_valid"},  64'(b4.result_valid), 64'd1);
      checkOutput({vecs[v].name, "_result"}, 64'(b4.result),       64'(vecs[v].expected));
      checkOutput({vecs[v].name, "_cnt"},    64'(b4.digit_cnt),    64'd4);
      tick();
      checkOutput({vecs[v].name, "_valid_pulse"}, 64'(b4.result_valid), 64'd0);
      checkOutput({vecs[v].name, "_result_hold"}, 64'(b4.result),       64'(vecs[v].expected));
    end

    // Abort with the second digit: error wins over the digit, result keeps -1/16.
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    checkOutput("abort_busy_run", 64'(b4.busy), 64'd1);
    feedDigit(2'b10);
    b4.error_flag  = 1'b1;
    b4.digit_valid = 1'b1;
    b4.digit_in    = 2'b10;
    tick();
    b4.error_flag  = 1'b0;
    b4.digit_valid = 1'b0;
    checkOutput("abort_pulse",  64'(b4.aborted),      64'd1);
    checkOutput("abort_busy",   64'(b4.busy),         64'd0);
    checkOutput("abort_result", 64'(b4.result),       64'h1f);
    checkOutput("abort_novalid",64'(b4.result_valid), 64'd0);
    checkOutput("abort_cnt",    64'(b4.digit_cnt),    64'd1);
    tick();
    checkOutput("abort_pulse_end", 64'(b4.aborted), 64'd0);
    applyStimulus(8'b10_00_01_10);
    tick();
    checkOutput("after_abort_valid",  64'(b4.result_valid), 64'd1);
    checkOutput("after_abort_result", 64'(b4.result),       64'h07);
    tick();

    // Stall mid-stream with a digit presented: nothing may be accepted.
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    feedDigit(2'b10);
    feedDigit(2'b00);
    b4.write_enable = 1'b0;
    b4.digit_valid  = 1'b1;
    b4.digit_in     = 2'b01;
    for (int s = 0; s < 3; s++) tick();
    checkOutput("stall_cnt",  64'(b4.digit_cnt), 64'd2);
    checkOutput("stall_busy", 64'(b4.busy),      64'd1);
    b4.write_enable = 1'b1;
    feedDigit(2'b01);
    feedDigit(2'b10);
    tick();
    checkOutput("stall_valid",  64'(b4.result_valid), 64'd1);
    checkOutput("stall_result", 64'(b4.result),       64'h07);
    tick();

    // start in IDLE with a digit and an error: digit ignored, error has no effect.
    b4.start       = 1'b1;
    b4.digit_valid = 1'b1;
    b4.digit_in    = 2'b10;
    b4.error_flag  = 1'b1;
    tick();
    b4.start       = 1'b0;
    b4.digit_valid = 1'b0;
    b4.error_flag  = 1'b0;
    checkOutput("idle_start_busy", 64'(b4.busy),      64'd1);
    checkOutput("idle_start_cnt",  64'(b4.digit_cnt), 64'd0);
    feedDigit(2'b10);
    feedDigit(2'b01);

    // Async reset between edges clears outputs without waiting for a clock.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy",   64'(b4.busy),      64'd0);
    checkOutput("async_result", 64'(b4.result),    64'd0);
    checkOutput("async_cnt",    64'(b4.digit_cnt), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // 32-digit random streams against a weighted-sum model.
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      for (int i = 1; i <= 32; i++) begin
        rd = 2'($urandom_range(0, 3));
        if (rd == 2'b10) acc = acc + (longint'(1) <<< (32 - i));
        if (rd == 2'b01) acc = acc - (longint'(1) <<< (32 - i));
        b32.digit_valid = 1'b1;
        b32.digit_in    = rd;
        tick();
      end
      b32.digit_valid = 1'b0;
      exp32 = acc[32:0];
      seen  = 1'b0;
      for (int w = 0; w < 5 && !seen; w++) begin
        tick();
        if (b32.result_valid) seen = 1'b1;
      end
      checkOutput("rand32_valid_seen", 64'(seen), 64'd1);
      checkOutput("rand32_result",     64'(b32.result), 64'(exp32));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
